// File: rtl/ice40_ram_arbiter.sv
// ---------------------------------------------------------------------------
// ice40_ram_arbiter
//
// Shares one iCE40 SB_RAM40_4K block between two requesters, A and B. The
// RAM has independent read and write ports, so one read and one write can be
// accepted per cycle. When both requesters want the same port, a round-robin
// priority flop picks the winner. Granted commands are registered onto the
// RAM pins, and read data is steered back to the requester that issued it.
//
// Ports:
//   CLK, ASYNCRESETN        clock and asynchronous active-low reset
//   A_/B_VALID, A_/B_READY  request handshake (READY is combinational)
//   A_/B_WE                 1 = write, 0 = read
//   A_/B_ADDR               word address
//   A_/B_WDATA, A_/B_MASK   write data and bit mask (1 = bit not written)
//   A_/B_RVALID, A_/B_RDATA one-cycle read response strobe and data
//   RAM_RADDR, RAM_WADDR    registered RAM addresses
//   RAM_RE, RAM_WE          registered RAM port enables
//   RAM_WDATA, RAM_MASK     registered write data and mask
//   RAM_RCLKE, RAM_WCLKE    RAM clock enables, always 1
//   RAM_RDATA               RAM read data
// ---------------------------------------------------------------------------
module ice40_ram_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  ASYNCRESETN,

    input  logic                  A_VALID,
    output logic                  A_READY,
    input  logic                  A_WE,
    input  logic [ADDR_WIDTH-1:0] A_ADDR,
    input  logic [DATA_WIDTH-1:0] A_WDATA,
    input  logic [DATA_WIDTH-1:0] A_MASK,
    output logic                  A_RVALID,
    output logic [DATA_WIDTH-1:0] A_RDATA,

    input  logic                  B_VALID,
    output logic                  B_READY,
    input  logic                  B_WE,
    input  logic [ADDR_WIDTH-1:0] B_ADDR,
    input  logic [DATA_WIDTH-1:0] B_WDATA,
    input  logic [DATA_WIDTH-1:0] B_MASK,
    output logic                  B_RVALID,
    output logic [DATA_WIDTH-1:0] B_RDATA,

    output logic [ADDR_WIDTH-1:0] RAM_RADDR,
    output logic [ADDR_WIDTH-1:0] RAM_WADDR,
    output logic                  RAM_RE,
    output logic                  RAM_WE,
    output logic [DATA_WIDTH-1:0] RAM_WDATA,
    output logic [DATA_WIDTH-1:0] RAM_MASK,
    output logic                  RAM_RCLKE,
    output logic                  RAM_WCLKE,
    input  logic [DATA_WIDTH-1:0] RAM_RDATA
);

    // Priority flop: 0 favours A, 1 favours B on a same-port conflict.
    logic                  r_prio;

    logic                  r_ramRe;
    logic                  r_ramWe;
    logic [ADDR_WIDTH-1:0] r_ramRaddr;
    logic [ADDR_WIDTH-1:0] r_ramWaddr;
    logic [DATA_WIDTH-1:0] r_ramWdata;
    logic [DATA_WIDTH-1:0] r_ramMask;

    // Read tag: which requester owns the read currently at the RAM port.
    logic                  r_tagB;
    logic                  r_rvalidA;
    logic                  r_rvalidB;

    logic                  w_aRd;
    logic                  w_bRd;
    logic                  w_aWr;
    logic                  w_bWr;
    logic                  w_wrGrantA;
    logic                  w_wrGrantB;
    logic                  w_wrGrant;
    logic [ADDR_WIDTH-1:0] w_wrAddr;
    logic [DATA_WIDTH-1:0] w_wrData;
    logic [DATA_WIDTH-1:0] w_wrMask;
    logic                  w_rdPickA;
    logic                  w_rdPickB;
    logic [ADDR_WIDTH-1:0] w_rdAddr;
    logic                  w_collide;
    logic                  w_rdGrantA;
    logic                  w_rdGrantB;
    logic                  w_rdGrant;
    logic                  w_nextPrio;

    always_comb begin
        w_aRd      = A_VALID & ~A_WE;
        w_bRd      = B_VALID & ~B_WE;
        w_aWr      = A_VALID &  A_WE;
        w_bWr      = B_VALID &  B_WE;

        w_wrGrantA = w_aWr & (~w_bWr | ~r_prio);
        w_wrGrantB = w_bWr & (~w_aWr |  r_prio);
        w_wrGrant  = w_wrGrantA | w_wrGrantB;
        w_wrAddr   = w_wrGrantB ? B_ADDR  : A_ADDR;
        w_wrData   = w_wrGrantB ? B_WDATA : A_WDATA;
        w_wrMask   = w_wrGrantB ? B_MASK  : A_MASK;

        w_rdPickA  = w_aRd & (~w_bRd | ~r_prio);
        w_rdPickB  = w_bRd & (~w_aRd |  r_prio);
        w_rdAddr   = w_rdPickB ? B_ADDR : A_ADDR;

        // A same-cycle read and write to one address has undefined RAM
        // behaviour, so the write goes first and the reader retries next
        // cycle, when it sees the new data.
        w_collide  = w_wrGrant & (w_rdPickA | w_rdPickB) & (w_rdAddr == w_wrAddr);
        w_rdGrantA = w_rdPickA & ~w_collide;
        w_rdGrantB = w_rdPickB & ~w_collide;
        w_rdGrant  = w_rdGrantA | w_rdGrantB;

        // After a conflict priority passes to the loser; the winner had
        // priority, so that is simply the inverse. A collision is never a
        // conflict because each requester issues one request per cycle.
        w_nextPrio = r_prio;
        if ((w_aWr & w_bWr) | (w_aRd & w_bRd)) begin
            w_nextPrio = ~r_prio;
        end
    end

    assign A_READY   = ASYNCRESETN & (w_wrGrantA | w_rdGrantA);
    assign B_READY   = ASYNCRESETN & (w_wrGrantB | w_rdGrantB);

    assign RAM_RE    = r_ramRe;
    assign RAM_WE    = r_ramWe;
    assign RAM_RADDR = r_ramRaddr;
    assign RAM_WADDR = r_ramWaddr;
    assign RAM_WDATA = r_ramWdata;
    assign RAM_MASK  = r_ramMask;
    assign RAM_RCLKE = 1'b1;
    assign RAM_WCLKE = 1'b1;

    assign A_RVALID  = r_rvalidA;
    assign B_RVALID  = r_rvalidB;
    assign A_RDATA   = RAM_RDATA;
    assign B_RDATA   = RAM_RDATA;

    // Command registers and priority. Enables pulse for one cycle per grant;
    // address/data/mask only load on a grant so the RAM pins stay quiet.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_prio     <= 1'b0;
            r_ramRe    <= 1'b0;
            r_ramWe    <= 1'b0;
            r_ramRaddr <= '0;
            r_ramWaddr <= '0;
            r_ramWdata <= '0;
            r_ramMask  <= '0;
        end else begin
            r_prio  <= w_nextPrio;
            r_ramRe <= w_rdGrant;
            r_ramWe <= w_wrGrant;
            if (w_rdGrant) begin
                r_ramRaddr <= w_rdAddr;
            end
            if (w_wrGrant) begin
                r_ramWaddr <= w_wrAddr;
                r_ramWdata <= w_wrData;
                r_ramMask  <= w_wrMask;
            end
        end
    end

    // Read tag pipeline. The tag is valid while r_ramRe is high; one stage
    // later the RAM output is ready and the matching RVALID fires.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_tagB    <= 1'b0;
            r_rvalidA <= 1'b0;
            r_rvalidB <= 1'b0;
        end else begin
            if (w_rdGrant) begin
                r_tagB <= w_rdGrantB;
            end
            r_rvalidA <= r_ramRe & ~r_tagB;
            r_rvalidB <= r_ramRe &  r_tagB;
        end
    end

endmodule
